// File: rtl/f_d_pipe_reg.sv
// rtl/f_d_pipe_reg.sv - Fetch/Decode pipeline register with delay-slot tracking, stall and flush
// Holds the fetched word for decode; F_BD flags the word now in fetch as a delay slot.
module f_d_pipe_reg #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          EXC_W      = 5,
  parameter logic [EXC_W-1:0] EXC_ADEL = 5'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic [31:0]      F_pc,
  input  logic [31:0]      F_instr,
  input  logic             F_excAdEL,
  output logic [31:0]      D_pc,
  output logic [31:0]      D_instr,
  output logic [EXC_W-1:0] D_excCode,
  output logic             D_BD,
  output logic             D_valid,
  output logic             F_BD
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_cti;

  assign opcode = D_instr[31:26];
  assign funct  = D_instr[5:0];

  // Branches, jumps, REGIMM (any rt) and jr/jalr all own a delay slot; eret does not.
  always_comb begin
    is_cti = 1'b0;
    unique case (opcode)
      6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111: is_cti = 1'b1;
      6'b000000: is_cti = (funct == 6'b001000) || (funct == 6'b001001);
      default:   is_cti = 1'b0;
    endcase
  end

  // Bubbles carry D_instr=0, so gating with D_valid only guards against stray reset/flush contents.
  assign F_BD = D_valid & is_cti;

  always_ff @(posedge clk) begin
    if (reset) begin
      D_pc      <= RESET_PC;
      D_instr   <= '0;
      D_excCode <= '0;
      D_BD      <= 1'b0;
      D_valid   <= 1'b0;
    end else if (req) begin
      D_pc      <= HANDLER_PC;
      D_instr   <= '0;
      D_excCode <= '0;
      D_BD      <= 1'b0;
      D_valid   <= 1'b0;
    end else if (!stall) begin
      D_pc      <= F_pc;
      D_instr   <= F_excAdEL ? 32'h0 : F_instr;
      D_excCode <= F_excAdEL ? EXC_ADEL : '0;
      D_BD      <= F_BD;
      D_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_f_d_pipe_reg.sv
// tb/tb_f_d_pipe_reg.sv - scoreboard bench for f_d_pipe_reg
// Driver pushes hand-computed post-edge state per vector; monitor pops and compares after each edge.
module tb_f_d_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, req, stall, F_excAdEL;
  logic [31:0] F_pc, F_instr;
  logic [31:0] D_pc, D_instr;
  logic [4:0]  D_excCode;
  logic        D_BD, D_valid, F_BD;

  f_d_pipe_reg dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .F_pc(F_pc), .F_instr(F_instr), .F_excAdEL(F_excAdEL),
    .D_pc(D_pc), .D_instr(D_instr), .D_excCode(D_excCode),
    .D_BD(D_BD), .D_valid(D_valid), .F_BD(F_BD)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, rq, st, adel;
    logic [31:0] fpc, finstr;
    logic [31:0] epc, einstr;
    logic [4:0]  eexc;
    logic        ebd, evalid, efbd;
  } vec_t;

  typedef struct packed {
    logic [31:0] epc, einstr;
    logic [4:0]  eexc;
    logic        ebd, evalid, efbd;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  exp_t sb [$];
  int total = 0;
  int bad   = 0;
  int vidx  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, vidx, act, req_v);
    end
  endtask

  initial begin
    //        rst  rq   st   adel fpc           finstr        epc           einstr        exc  bd   val  fbd
    vecs[0]  = {1'b1,1'b0,1'b0,1'b0,32'h3000,32'h0,       32'h3000,32'h0,       5'd0,1'b0,1'b0,1'b0};
    vecs[1]  = {1'b1,1'b0,1'b0,1'b0,32'h3000,32'h0,       32'h3000,32'h0,       5'd0,1'b0,1'b0,1'b0};
    vecs[2]  = {1'b0,1'b0,1'b0,1'b0,32'h3000,32'h24010001,32'h3000,32'h24010001,5'd0,1'b0,1'b1,1'b0};
    vecs[3]  = {1'b0,1'b0,1'b0,1'b0,32'h3000,32'h10220003,32'h3000,32'h10220003,5'd0,1'b0,1'b1,1'b1};
    vecs[4]  = {1'b0,1'b0,1'b0,1'b0,32'h3004,32'h0,       32'h3004,32'h0,       5'd0,1'b1,1'b1,1'b0};
    vecs[5]  = {1'b0,1'b0,1'b0,1'b0,32'h3008,32'h24020002,32'h3008,32'h24020002,5'd0,1'b0,1'b1,1'b0};
    vecs[6]  = {1'b0,1'b0,1'b1,1'b0,32'h300c,32'h11111111,32'h3008,32'h24020002,5'd0,1'b0,1'b1,1'b0};
    vecs[7]  = {1'b0,1'b0,1'b1,1'b0,32'h3010,32'h22222222,32'h3008,32'h24020002,5'd0,1'b0,1'b1,1'b0};
    vecs[8]  = {1'b0,1'b0,1'b1,1'b1,32'h3014,32'h0,       32'h3008,32'h24020002,5'd0,1'b0,1'b1,1'b0};
    vecs[9]  = {1'b0,1'b0,1'b0,1'b0,32'h3018,32'h24030003,32'h3018,32'h24030003,5'd0,1'b0,1'b1,1'b0};
    vecs[10] = {1'b0,1'b0,1'b0,1'b0,32'h301c,32'h0C000c00,32'h301c,32'h0C000c00,5'd0,1'b0,1'b1,1'b1};
    vecs[11] = {1'b0,1'b1,1'b1,1'b0,32'h3020,32'h24050005,32'h4180,32'h0,       5'd0,1'b0,1'b0,1'b0};
    vecs[12] = {1'b0,1'b0,1'b0,1'b0,32'h3024,32'h24040004,32'h3024,32'h24040004,5'd0,1'b0,1'b1,1'b0};
    vecs[13] = {1'b0,1'b0,1'b0,1'b0,32'h3028,32'h00000008,32'h3028,32'h00000008,5'd0,1'b0,1'b1,1'b1};
    vecs[14] = {1'b0,1'b0,1'b0,1'b1,32'h3002,32'h0,       32'h3002,32'h0,       5'd4,1'b1,1'b1,1'b0};
    vecs[15] = {1'b0,1'b0,1'b0,1'b0,32'h3030,32'h0C000c00,32'h3030,32'h0C000c00,5'd0,1'b0,1'b1,1'b1};
    vecs[16] = {1'b1,1'b0,1'b1,1'b0,32'h3034,32'h24060006,32'h3000,32'h0,       5'd0,1'b0,1'b0,1'b0};
    vecs[17] = {1'b1,1'b1,1'b0,1'b0,32'h3038,32'h24070007,32'h3000,32'h0,       5'd0,1'b0,1'b0,1'b0};
    vecs[18] = {1'b0,1'b0,1'b0,1'b0,32'h3000,32'h42000018,32'h3000,32'h42000018,5'd0,1'b0,1'b1,1'b0};
    vecs[19] = {1'b0,1'b0,1'b0,1'b0,32'h3004,32'h04110001,32'h3004,32'h04110001,5'd0,1'b0,1'b1,1'b1};
    vecs[20] = {1'b0,1'b0,1'b0,1'b0,32'h3008,32'h0040f809,32'h3008,32'h0040f809,5'd0,1'b1,1'b1,1'b1};
    vecs[21] = {1'b0,1'b0,1'b0,1'b0,32'h300c,32'h00000020,32'h300c,32'h00000020,5'd0,1'b1,1'b1,1'b0};
    vecs[22] = {1'b0,1'b0,1'b0,1'b0,32'h3010,32'h08000c00,32'h3010,32'h08000c00,5'd0,1'b0,1'b1,1'b1};
  end

  // Driver: apply a vector on the falling edge and queue what D must show after the next rising edge.
  initial begin
    reset = 1'b1; req = 1'b0; stall = 1'b0; F_excAdEL = 1'b0;
    F_pc = 32'h0; F_instr = 32'h0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      req       = vecs[i].rq;
      stall     = vecs[i].st;
      F_excAdEL = vecs[i].adel;
      F_pc      = vecs[i].fpc;
      F_instr   = vecs[i].finstr;
      sb.push_back({vecs[i].epc, vecs[i].einstr, vecs[i].eexc,
                    vecs[i].ebd, vecs[i].evalid, vecs[i].efbd});
    end
    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    total++;
    if (vidx != NV) begin
      bad++;
      $display("FAIL checked actual=%0d required=%0d", vidx, NV);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: every rising edge with an outstanding expectation presents a new D state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("D_pc",      D_pc,             e.epc);
        chk("D_instr",   D_instr,          e.einstr);
        chk("D_excCode", {27'd0, D_excCode}, {27'd0, e.eexc});
        chk("D_BD",      {31'd0, D_BD},    {31'd0, e.ebd});
        chk("D_valid",   {31'd0, D_valid}, {31'd0, e.evalid});
        chk("F_BD",      {31'd0, F_BD},    {31'd0, e.efbd});
        vidx++;
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
